// File: rtl/dpwm_duty_controller.sv
// Button-driven duty/frequency controller for a DPWM: synchronizes and debounces the
// buttons, steps duty/frequency with auto-repeat, and interlocks the BUCK/bridge enables.
module dpwm_duty_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_PERIOD   = 8,
  parameter int unsigned DEAD_CYCLES     = 3
) (
  input  logic       CLK_FPGA_BOARD,
  input  logic       reinicio,
  input  logic       boton_aumentar,
  input  logic       boton_disminuir,
  input  logic       seleccion_funcion,
  input  logic       seleccion_salida,
  output logic [3:0] duty_cycle,
  output logic [1:0] freq_sel,
  output logic       buck_enable,
  output logic       bridge_enable,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       value_changed
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCW = $clog2(RMX + 1);
  localparam int unsigned DCW = $clog2(DEAD_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, STEP, HOLD, REPEAT, LOCK} btn_state_t;
  typedef enum logic [1:0] {RUN_BUCK, DEAD, RUN_BRIDGE} out_state_t;

  // Bit order: 0 = aumentar, 1 = disminuir, 2 = funcion, 3 = salida
  logic [3:0] sync1, sync2;
  logic [1:0] db, db_next;
  logic [DBW-1:0] db_cnt [2];

  btn_state_t btn_state, btn_next;
  logic [RCW-1:0] rep_cnt, rep_cnt_next;
  logic dir_up, dir_up_next, do_step;
  logic both, released;

  out_state_t out_state, out_next;
  logic [DCW-1:0] dead_cnt, dead_cnt_next;
  logic target, target_next;

  logic [3:0] duty_q;
  logic [1:0] freq_q;
  logic [3:0] active_val, tens_next, ones_next;

  always_ff @(posedge CLK_FPGA_BOARD) begin
    if (reinicio) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {seleccion_salida, seleccion_funcion, boton_disminuir, boton_aumentar};
      sync2 <= sync1;
    end
  end

  // A level is accepted on the cycle its hold count completes, so the FSM sees it at once
  always_comb begin
    db_next = db;
    for (int i = 0; i < 2; i++) begin
      if (sync2[i] != db[i] && db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) db_next[i] = sync2[i];
    end
  end

  always_ff @(posedge CLK_FPGA_BOARD) begin
    if (reinicio) begin
      db <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      db <= db_next;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i] || db_next[i] != db[i]) db_cnt[i] <= '0;
        else db_cnt[i] <= db_cnt[i] + DBW'(1);
      end
    end
  end

  always_ff @(posedge CLK_FPGA_BOARD) begin
    if (reinicio) begin
      btn_state <= IDLE;
      rep_cnt   <= '0;
      dir_up    <= 1'b0;
    end else begin
      btn_state <= btn_next;
      rep_cnt   <= rep_cnt_next;
      dir_up    <= dir_up_next;
    end
  end

  always_comb begin
    btn_next     = btn_state;
    rep_cnt_next = rep_cnt;
    dir_up_next  = dir_up;
    do_step      = 1'b0;
    both         = db_next[0] & db_next[1];
    released     = dir_up ? ~db_next[0] : ~db_next[1];
    case (btn_state)
      IDLE: begin
        rep_cnt_next = '0;
        if (both) btn_next = LOCK;
        else if (db_next[0] && !db[0]) begin
          btn_next    = STEP;
          dir_up_next = 1'b1;
        end else if (db_next[1] && !db[1]) begin
          btn_next    = STEP;
          dir_up_next = 1'b0;
        end
      end
      STEP: begin
        rep_cnt_next = '0;
        if (both) btn_next = LOCK;
        else begin
          do_step  = 1'b1;
          btn_next = HOLD;
        end
      end
      HOLD: begin
        if (both || released) begin
          btn_next     = both ? LOCK : IDLE;
          rep_cnt_next = '0;
        end else if (rep_cnt == RCW'(REPEAT_DELAY - 1)) begin
          btn_next     = REPEAT;
          rep_cnt_next = '0;
        end else rep_cnt_next = rep_cnt + RCW'(1);
      end
      REPEAT: begin
        if (both || released) begin
          btn_next     = both ? LOCK : IDLE;
          rep_cnt_next = '0;
        end else if (rep_cnt == RCW'(REPEAT_PERIOD - 1)) begin
          do_step      = 1'b1;
          rep_cnt_next = '0;
        end else rep_cnt_next = rep_cnt + RCW'(1);
      end
      LOCK: begin
        rep_cnt_next = '0;
        if (!db_next[0] && !db_next[1]) btn_next = IDLE;
      end
      default: begin
        btn_next     = IDLE;
        rep_cnt_next = '0;
      end
    endcase
  end

  // Saturating step on whichever value the function select points at right now
  always_ff @(posedge CLK_FPGA_BOARD) begin
    if (reinicio) begin
      duty_cycle    <= 4'd8;
      freq_sel      <= 2'd0;
      duty_q        <= 4'd8;
      freq_q        <= 2'd0;
      value_changed <= 1'b0;
      bcd_tens      <= 4'd0;
      bcd_ones      <= 4'd8;
    end else begin
      if (do_step) begin
        if (sync2[2]) begin
          if (dir_up && freq_sel != 2'd3) freq_sel <= freq_sel + 2'd1;
          else if (!dir_up && freq_sel != 2'd0) freq_sel <= freq_sel - 2'd1;
        end else begin
          if (dir_up && duty_cycle != 4'd15) duty_cycle <= duty_cycle + 4'd1;
          else if (!dir_up && duty_cycle != 4'd0) duty_cycle <= duty_cycle - 4'd1;
        end
      end
      duty_q        <= duty_cycle;
      freq_q        <= freq_sel;
      value_changed <= (duty_cycle != duty_q) || (freq_sel != freq_q);
      bcd_tens      <= tens_next;
      bcd_ones      <= ones_next;
    end
  end

  always_comb begin
    active_val = sync2[2] ? {2'b00, freq_sel} : duty_cycle;
    tens_next  = (active_val >= 4'd10) ? 4'd1 : 4'd0;
    ones_next  = (active_val >= 4'd10) ? active_val - 4'd10 : active_val;
  end

  always_ff @(posedge CLK_FPGA_BOARD) begin
    if (reinicio) begin
      out_state     <= DEAD;
      dead_cnt      <= '0;
      target        <= 1'b0;
      buck_enable   <= 1'b0;
      bridge_enable <= 1'b0;
    end else begin
      out_state     <= out_next;
      dead_cnt      <= dead_cnt_next;
      target        <= target_next;
      buck_enable   <= (out_next == RUN_BUCK);
      bridge_enable <= (out_next == RUN_BRIDGE);
    end
  end

  // Break-before-make: any selection change restarts a full dead gap toward the newest target
  always_comb begin
    out_next      = out_state;
    dead_cnt_next = '0;
    target_next   = target;
    case (out_state)
      RUN_BUCK: begin
        if (sync2[3]) begin
          out_next    = DEAD;
          target_next = 1'b1;
        end
      end
      RUN_BRIDGE: begin
        if (!sync2[3]) begin
          out_next    = DEAD;
          target_next = 1'b0;
        end
      end
      DEAD: begin
        if (sync2[3] != target) target_next = sync2[3];
        else if (dead_cnt == DCW'(DEAD_CYCLES - 1)) out_next = target ? RUN_BRIDGE : RUN_BUCK;
        else dead_cnt_next = dead_cnt + DCW'(1);
      end
      default: out_next = DEAD;
    endcase
  end

endmodule

// File: tb/tb_dpwm_duty_controller.sv
// Directed bench for dpwm_duty_controller: button stepping, repeat, saturation, lock,
// output interlock, glitch rejection and mid-operation reset.
module tb_dpwm_duty_controller;

  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 20;
  localparam int unsigned RP  = 8;

  logic clk = 1'b0;
  logic rst, up, dn, fsel, osel;
  logic [3:0] duty_cycle, bcd_tens, bcd_ones;
  logic [1:0] freq_sel;
  logic buck_enable, bridge_enable, value_changed;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dpwm_duty_controller #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .DEAD_CYCLES(3)
  ) dut (
    .CLK_FPGA_BOARD(clk), .reinicio(rst), .boton_aumentar(up), .boton_disminuir(dn),
    .seleccion_funcion(fsel), .seleccion_salida(osel), .duty_cycle(duty_cycle),
    .freq_sel(freq_sel), .buck_enable(buck_enable), .bridge_enable(bridge_enable),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .value_changed(value_changed)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; up = 1'b0; dn = 1'b0; fsel = 1'b0; osel = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(6);
  endtask

  // Drive one button for hold cycles, release for gap cycles, counting value_changed pulses
  task automatic press(input bit is_up, input int hold, input int gap, output int pulses);
    pulses = 0;
    if (is_up) up = 1'b1; else dn = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick(1);
      if (value_changed) pulses++;
    end
    up = 1'b0; dn = 1'b0;
    for (int i = 0; i < gap; i++) begin
      tick(1);
      if (value_changed) pulses++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; up = 1'b0; dn = 1'b0; fsel = 1'b0; osel = 1'b0;
    tick(2);
    checks++; if (duty_cycle !== 4'd8) begin failures++; $display("FAIL reset_duty: got %0d expected 8", duty_cycle); end
    checks++; if (freq_sel !== 2'd0) begin failures++; $display("FAIL reset_freq: got %0d expected 0", freq_sel); end
    checks++; if (value_changed !== 1'b0) begin failures++; $display("FAIL reset_vc: got %b expected 0", value_changed); end
    checks++; if ({bcd_tens, bcd_ones} !== 8'h08) begin failures++; $display("FAIL reset_bcd: got %0d/%0d expected 0/8", bcd_tens, bcd_ones); end
    checks++; if ({buck_enable, bridge_enable} !== 2'b00) begin failures++; $display("FAIL reset_enables: got %b%b expected 00", buck_enable, bridge_enable); end
    rst = 1'b0;
    tick(2);
    checks++; if ({buck_enable, bridge_enable} !== 2'b00) begin failures++; $display("FAIL reset_dead_gap: got %b%b expected 00", buck_enable, bridge_enable); end
    tick(1);
    checks++; if ({buck_enable, bridge_enable} !== 2'b10) begin failures++; $display("FAIL reset_run_buck: got %b%b expected 10", buck_enable, bridge_enable); end
    tick(3);
  endtask

  task automatic test_single_step();
    int pulses;
    pulses = 0;
    up = 1'b1;
    tick(DEB + 2);
    checks++; if (duty_cycle !== 4'd8) begin failures++; $display("FAIL step_early: got %0d expected 8", duty_cycle); end
    tick(1);
    checks++; if (duty_cycle !== 4'd9) begin failures++; $display("FAIL step_latency: got %0d expected 9", duty_cycle); end
    checks++; if (value_changed !== 1'b0) begin failures++; $display("FAIL step_vc_early: got %b expected 0", value_changed); end
    tick(1);
    if (value_changed) pulses++;
    checks++; if (value_changed !== 1'b1) begin failures++; $display("FAIL step_vc_pulse: got %b expected 1", value_changed); end
    checks++; if ({bcd_tens, bcd_ones} !== 8'h09) begin failures++; $display("FAIL step_bcd: got %0d/%0d expected 0/9", bcd_tens, bcd_ones); end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (value_changed) pulses++;
    end
    up = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (value_changed) pulses++;
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL step_vc_count: got %0d expected 1", pulses); end
    checks++; if (duty_cycle !== 4'd9) begin failures++; $display("FAIL step_final: got %0d expected 9", duty_cycle); end
  endtask

  task automatic test_repeat();
    int pulses, n, exp_duty;
    apply_reset();
    pulses = 0;
    up = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      tick(1);
      if (value_changed) pulses++;
      n = 0;
      if (i >= int'(DEB + 3)) n = 1;
      if (i >= int'(DEB + 3 + RD + RP)) n += (i - int'(DEB + 3 + RD)) / int'(RP);
      exp_duty = (8 + n > 15) ? 15 : 8 + n;
      checks++; if (duty_cycle !== 4'(exp_duty)) begin failures++; $display("FAIL repeat_duty cycle %0d: got %0d expected %0d", i, duty_cycle, exp_duty); end
    end
    checks++; if (pulses !== 7) begin failures++; $display("FAIL repeat_vc_count: got %0d expected 7", pulses); end
    checks++; if ({bcd_tens, bcd_ones} !== 8'h15) begin failures++; $display("FAIL repeat_bcd: got %0d/%0d expected 1/5", bcd_tens, bcd_ones); end
    up = 1'b0;
    tick(15);
  endtask

  task automatic test_freq_saturation();
    int pulses, total;
    apply_reset();
    fsel = 1'b1;
    tick(3);
    checks++; if ({bcd_tens, bcd_ones} !== 8'h00) begin failures++; $display("FAIL freq_bcd_zero: got %0d/%0d expected 0/0", bcd_tens, bcd_ones); end
    total = 0;
    for (int k = 0; k < 3; k++) begin
      press(1'b0, 10, 12, pulses);
      total += pulses;
    end
    checks++; if (freq_sel !== 2'd0) begin failures++; $display("FAIL freq_floor: got %0d expected 0", freq_sel); end
    checks++; if (total !== 0) begin failures++; $display("FAIL freq_floor_vc: got %0d expected 0", total); end
    total = 0;
    for (int k = 1; k <= 5; k++) begin
      press(1'b1, 10, 12, pulses);
      total += pulses;
      checks++; if (freq_sel !== 2'((k > 3) ? 3 : k)) begin failures++; $display("FAIL freq_up press %0d: got %0d expected %0d", k, freq_sel, (k > 3) ? 3 : k); end
    end
    checks++; if (total !== 3) begin failures++; $display("FAIL freq_ceiling_vc: got %0d expected 3", total); end
    checks++; if ({bcd_tens, bcd_ones} !== 8'h03) begin failures++; $display("FAIL freq_bcd: got %0d/%0d expected 0/3", bcd_tens, bcd_ones); end
    checks++; if (duty_cycle !== 4'd8) begin failures++; $display("FAIL freq_duty_untouched: got %0d expected 8", duty_cycle); end
    fsel = 1'b0;
    tick(4);
  endtask

  task automatic test_lock();
    int pulses;
    apply_reset();
    pulses = 0;
    up = 1'b1; dn = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if (i == 15) up = 1'b0;
      if (i == 30) dn = 1'b0;
      tick(1);
      if (value_changed) pulses++;
    end
    checks++; if (duty_cycle !== 4'd8) begin failures++; $display("FAIL lock_duty: got %0d expected 8", duty_cycle); end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL lock_vc: got %0d expected 0", pulses); end
    press(1'b1, 10, 12, pulses);
    checks++; if (duty_cycle !== 4'd9) begin failures++; $display("FAIL lock_fresh_step: got %0d expected 9", duty_cycle); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL lock_fresh_vc: got %0d expected 1", pulses); end
  endtask

  task automatic test_output_select();
    osel = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      checks++; if (buck_enable && bridge_enable) begin failures++; $display("FAIL sel_overlap a%0d: got 11 expected not both", i); end
      if (i == 2) begin
        checks++; if ({buck_enable, bridge_enable} !== 2'b10) begin failures++; $display("FAIL sel_sync_delay: got %b%b expected 10", buck_enable, bridge_enable); end
      end
      if (i == 3 || i == 5) begin
        checks++; if ({buck_enable, bridge_enable} !== 2'b00) begin failures++; $display("FAIL sel_dead c%0d: got %b%b expected 00", i, buck_enable, bridge_enable); end
      end
      if (i == 6) begin
        checks++; if ({buck_enable, bridge_enable} !== 2'b01) begin failures++; $display("FAIL sel_bridge_on: got %b%b expected 01", buck_enable, bridge_enable); end
      end
    end
    osel = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (i == 3) osel = 1'b1;
      checks++; if (buck_enable && bridge_enable) begin failures++; $display("FAIL sel_overlap b%0d: got 11 expected not both", i); end
      if (i == 3 || i == 6 || i == 8) begin
        checks++; if ({buck_enable, bridge_enable} !== 2'b00) begin failures++; $display("FAIL sel_retarget_dead c%0d: got %b%b expected 00", i, buck_enable, bridge_enable); end
      end
      if (i == 9 || i == 12) begin
        checks++; if ({buck_enable, bridge_enable} !== 2'b01) begin failures++; $display("FAIL sel_retarget_on c%0d: got %b%b expected 01", i, buck_enable, bridge_enable); end
      end
    end
  endtask

  task automatic test_glitch_and_reset();
    int pulses;
    apply_reset();
    press(1'b1, 2, 15, pulses);
    checks++; if (duty_cycle !== 4'd8) begin failures++; $display("FAIL glitch_duty: got %0d expected 8", duty_cycle); end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL glitch_vc: got %0d expected 0", pulses); end
    up = 1'b1;
    tick(40);
    checks++; if (duty_cycle !== 4'd10) begin failures++; $display("FAIL midrun_duty: got %0d expected 10", duty_cycle); end
    rst = 1'b1; up = 1'b0;
    tick(1);
    checks++; if (duty_cycle !== 4'd8) begin failures++; $display("FAIL abort_duty: got %0d expected 8", duty_cycle); end
    checks++; if ({buck_enable, bridge_enable} !== 2'b00) begin failures++; $display("FAIL abort_enables: got %b%b expected 00", buck_enable, bridge_enable); end
    checks++; if (value_changed !== 1'b0) begin failures++; $display("FAIL abort_vc: got %b expected 0", value_changed); end
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (value_changed) pulses++;
    end
    checks++; if (duty_cycle !== 4'd8 || pulses !== 0) begin failures++; $display("FAIL abort_no_step: got duty %0d pulses %0d expected 8 and 0", duty_cycle, pulses); end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_repeat();
    test_freq_saturation();
    test_lock();
    test_output_select();
    test_glitch_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
